// File: rtl/bist_pkg.sv
// Shared types and default parameters for the ALU BIST response analyzer.
// Imported by the MISR and the run controller.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEED    = 3'd1,
        RUN     = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int              DEF_DATA_W    = 9;
    localparam int              DEF_ADDR_W    = 8;
    localparam int              DEF_SIG_W     = 16;
    localparam logic [15:0]     DEF_MISR_POLY = 16'h1021;
    localparam logic [15:0]     DEF_MISR_SEED = 16'h0000;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift left, fold POLY in when the MSB
// falls out, then XOR in the zero-extended response word.
module bist_misr
    import bist_pkg::*;
#(
    parameter int               SIG_W     = DEF_SIG_W,
    parameter int               DATA_W    = DEF_DATA_W,
    parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(DEF_MISR_POLY)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [SIG_W-1:0]  seed,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
                  ^ SIG_W'(din);
        end
    end

    // Reset returns to the seed so a mid-run abort leaves no partial signature.
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= seed;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST run controller: steps the ROM address for TEST_LEN words, counts
// response mismatches, compacts responses in a MISR and grades the run.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                TEST_LEN   = 256,
    parameter int                SIG_W      = DEF_SIG_W,
    parameter logic [SIG_W-1:0]  MISR_POLY  = SIG_W'(DEF_MISR_POLY),
    parameter logic [SIG_W-1:0]  MISR_SEED  = SIG_W'(DEF_MISR_SEED),
    parameter logic [SIG_W-1:0]  GOLDEN_SIG = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] address,
    output logic              test_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SIG_W-1:0]  signature,
    output logic [ADDR_W:0]   fail_count,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TEST_LEN - 1);
    localparam logic [ADDR_W:0]   FAIL_MAX  = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   fail_q, fail_d;
    logic              ffv_q, ffv_d;
    logic [ADDR_W-1:0] ffa_q, ffa_d;
    logic              pass_q, pass_d;
    logic [SIG_W-1:0]  sig;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fail_d  = fail_q;
        ffv_d   = ffv_q;
        ffa_d   = ffa_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SEED;
                end
            end
            SEED: begin
                addr_d  = '0;
                fail_d  = '0;
                ffv_d   = 1'b0;
                ffa_d   = '0;
                pass_d  = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                addr_d = addr_q + 1'b1;
                // 4-state compare so an X/Z response from the ALU counts as a miss.
                if (alu_data !== rom_data) begin
                    if (fail_q != FAIL_MAX) begin
                        fail_d = fail_q + 1'b1;
                    end
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffa_d = addr_q;
                    end
                end
                if (addr_q == LAST_ADDR) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                pass_d  = (fail_q == '0) && (sig == GOLDEN_SIG);
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            fail_q  <= '0;
            ffv_q   <= 1'b0;
            ffa_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fail_q  <= fail_d;
            ffv_q   <= ffv_d;
            ffa_q   <= ffa_d;
            pass_q  <= pass_d;
        end
    end

    bist_misr #(
        .SIG_W     (SIG_W),
        .DATA_W    (DATA_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (state_q == SEED),
        .seed  (MISR_SEED),
        .en    (state_q == RUN),
        .din   (alu_data),
        .sig   (sig)
    );

    assign address          = addr_q;
    assign test_en          = (state_q == RUN);
    assign busy             = (state_q == SEED) || (state_q == RUN) || (state_q == COMPARE);
    assign done             = (state_q == DONE);
    assign pass             = pass_q && (state_q == DONE);
    assign signature        = sig;
    assign fail_count       = fail_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_addr  = ffa_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed bench: four analyzer instances with different run lengths and
// golden signatures, fed by a small upstream ALU/ROM model keyed on address.
module tb_bist_response_analyzer;

    localparam int U4   = 0;   // TEST_LEN=4,   golden 0
    localparam int U2   = 1;   // TEST_LEN=2,   golden 16'h0002
    localparam int U8   = 2;   // TEST_LEN=8,   golden 0
    localparam int U256 = 3;   // TEST_LEN=256, golden 0

    logic        clk = 1'b0;
    logic        reset_s [4];
    logic        start_s [4];
    logic [8:0]  alu_d   [4];
    logic [8:0]  rom_d   [4];
    logic [7:0]  addr_s  [4];
    logic        test_en_s [4];
    logic        busy_s  [4];
    logic        done_s  [4];
    logic        pass_s  [4];
    logic [15:0] sig_s   [4];
    logic [8:0]  fail_s  [4];
    logic        ffv_s   [4];
    logic [7:0]  ffa_s   [4];
    int          mode    [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        bist_response_analyzer #(
            .DATA_W     (9),
            .ADDR_W     (8),
            .TEST_LEN   (gi == 0 ? 4 : gi == 1 ? 2 : gi == 2 ? 8 : 256),
            .SIG_W      (16),
            .MISR_POLY  (16'h1021),
            .MISR_SEED  (16'h0000),
            .GOLDEN_SIG (gi == 1 ? 16'h0002 : 16'h0000)
        ) u_dut (
            .clk              (clk),
            .reset            (reset_s[gi]),
            .start            (start_s[gi]),
            .alu_data         (alu_d[gi]),
            .rom_data         (rom_d[gi]),
            .address          (addr_s[gi]),
            .test_en          (test_en_s[gi]),
            .busy             (busy_s[gi]),
            .done             (done_s[gi]),
            .pass             (pass_s[gi]),
            .signature        (sig_s[gi]),
            .fail_count       (fail_s[gi]),
            .first_fail_valid (ffv_s[gi]),
            .first_fail_addr  (ffa_s[gi])
        );
    end

    // Upstream model: 0 zeros, 1 one-hot word at addr 0, 2 miss only at addr 5,
    // 3 every word mismatching, 4 address-derived matching data.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            logic [8:0] a;
            logic [8:0] r;
            a = '0;
            r = '0;
            case (mode[i])
                1: begin a = (addr_s[i] == 8'd0) ? 9'h001 : 9'h000; r = a; end
                2: begin a = {addr_s[i] + 8'h30, addr_s[i][0]}; r = a ^ {8'h00, addr_s[i] == 8'd5}; end
                3: begin a = {addr_s[i], 1'b1}; r = ~a; end
                4: begin a = {addr_s[i], addr_s[i][0]}; r = a; end
                default: begin a = '0; r = '0; end
            endcase
            alu_d[i] = a;
            rom_d[i] = r;
        end
    end

    // Stimulus helper: pulse start, then count cycles (negedges after the start
    // edge) until done, and how many of them had test_en high.
    task automatic run(input int idx, output int cycles, output int en_cnt);
        @(negedge clk) start_s[idx] = 1'b1;
        @(negedge clk) start_s[idx] = 1'b0;
        cycles = 0;
        en_cnt = 0;
        while (!done_s[idx] && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (test_en_s[idx]) en_cnt++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            reset_s[i] = 1'b1; start_s[i] = 1'b0; mode[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({addr_s[i], test_en_s[i], busy_s[i], done_s[i], pass_s[i]} !== 12'h000) begin n_bad++; $display("FAIL reset_ctrl[%0d]: got addr=%0d en=%b busy=%b done=%b pass=%b, want all 0", i, addr_s[i], test_en_s[i], busy_s[i], done_s[i], pass_s[i]); end
            n_cmp++; if ({sig_s[i], fail_s[i], ffv_s[i], ffa_s[i]} !== 34'h0) begin n_bad++; $display("FAIL reset_results[%0d]: got sig=%h fail=%0d ffv=%b ffa=%0d, want all 0", i, sig_s[i], fail_s[i], ffv_s[i], ffa_s[i]); end
        end
        start_s[U4] = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy_s[U4] !== 1'b0) begin n_bad++; $display("FAIL reset_beats_start: busy got %b want 0", busy_s[U4]); end
        start_s[U4] = 1'b0;
        for (int i = 0; i < 4; i++) reset_s[i] = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_all_zero();
        int cyc, en;
        mode[U4] = 0;
        run(U4, cyc, en);
        n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL zero_latency: done after %0d cycles, want 6", cyc); end
        n_cmp++; if (en !== 4) begin n_bad++; $display("FAIL zero_test_en: %0d cycles high, want 4", en); end
        n_cmp++; if (sig_s[U4] !== 16'h0000 || fail_s[U4] !== 9'd0) begin n_bad++; $display("FAIL zero_results: sig=%h fail=%0d, want 0000 and 0", sig_s[U4], fail_s[U4]); end
        n_cmp++; if (pass_s[U4] !== 1'b1) begin n_bad++; $display("FAIL zero_pass: got %b want 1", pass_s[U4]); end
        n_cmp++; if (addr_s[U4] !== 8'd4) begin n_bad++; $display("FAIL zero_addr_end: got %0d want 4", addr_s[U4]); end
        $display("test_all_zero: cycles=%0d en=%0d sig=%h pass=%b", cyc, en, sig_s[U4], pass_s[U4]);
    endtask

    task automatic test_misr_shift();
        int cyc, en;
        mode[U2] = 1;
        run(U2, cyc, en);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL misr_latency: got %0d want 4", cyc); end
        n_cmp++; if (sig_s[U2] !== 16'h0002) begin n_bad++; $display("FAIL misr_sig: got %h want 0002", sig_s[U2]); end
        n_cmp++; if (pass_s[U2] !== 1'b1) begin n_bad++; $display("FAIL misr_pass_golden: got %b want 1", pass_s[U2]); end
        $display("test_misr_shift: sig=%h pass=%b", sig_s[U2], pass_s[U2]);
        mode[U2] = 0;
        run(U2, cyc, en);
        n_cmp++; if (sig_s[U2] !== 16'h0000) begin n_bad++; $display("FAIL misr_zero_sig: got %h want 0000", sig_s[U2]); end
        n_cmp++; if (pass_s[U2] !== 1'b0) begin n_bad++; $display("FAIL misr_golden_miss: pass got %b want 0", pass_s[U2]); end
        $display("test_misr_golden_miss: sig=%h pass=%b", sig_s[U2], pass_s[U2]);
    endtask

    task automatic test_single_mismatch();
        int cyc, en;
        mode[U8] = 2;
        run(U8, cyc, en);
        n_cmp++; if (cyc !== 10 || en !== 8) begin n_bad++; $display("FAIL mm_timing: cycles=%0d en=%0d, want 10 and 8", cyc, en); end
        n_cmp++; if (fail_s[U8] !== 9'd1) begin n_bad++; $display("FAIL mm_count: got %0d want 1", fail_s[U8]); end
        n_cmp++; if (ffv_s[U8] !== 1'b1 || ffa_s[U8] !== 8'd5) begin n_bad++; $display("FAIL mm_first: valid=%b addr=%0d, want 1 and 5", ffv_s[U8], ffa_s[U8]); end
        n_cmp++; if (pass_s[U8] !== 1'b0) begin n_bad++; $display("FAIL mm_pass: got %b want 0", pass_s[U8]); end
        $display("test_single_mismatch: fail=%0d ffa=%0d pass=%b", fail_s[U8], ffa_s[U8], pass_s[U8]);
    endtask

    task automatic test_reset_mid_run();
        int cyc, en, w;
        mode[U8] = 3;
        @(negedge clk) start_s[U8] = 1'b1;
        @(negedge clk) start_s[U8] = 1'b0;
        w = 0;
        while (!(test_en_s[U8] && addr_s[U8] == 8'd3) && w < 20) begin @(negedge clk); w++; end
        n_cmp++; if (w >= 20) begin n_bad++; $display("FAIL rmr_reach_addr3: timeout, addr=%0d", addr_s[U8]); end
        n_cmp++; if (fail_s[U8] !== 9'd3) begin n_bad++; $display("FAIL rmr_partial_fail: got %0d want 3", fail_s[U8]); end
        reset_s[U8] = 1'b1;
        @(negedge clk);
        reset_s[U8] = 1'b0;
        n_cmp++; if (busy_s[U8] !== 1'b0 || test_en_s[U8] !== 1'b0 || done_s[U8] !== 1'b0 || addr_s[U8] !== 8'd0) begin n_bad++; $display("FAIL rmr_ctrl: busy=%b en=%b done=%b addr=%0d, want 0 0 0 0", busy_s[U8], test_en_s[U8], done_s[U8], addr_s[U8]); end
        n_cmp++; if (fail_s[U8] !== 9'd0 || sig_s[U8] !== 16'h0000 || ffv_s[U8] !== 1'b0) begin n_bad++; $display("FAIL rmr_results: fail=%0d sig=%h ffv=%b, want 0 0000 0", fail_s[U8], sig_s[U8], ffv_s[U8]); end
        mode[U8] = 0;
        run(U8, cyc, en);
        n_cmp++; if (cyc !== 10 || en !== 8) begin n_bad++; $display("FAIL rmr_rerun: cycles=%0d en=%0d, want 10 and 8", cyc, en); end
        n_cmp++; if (pass_s[U8] !== 1'b1) begin n_bad++; $display("FAIL rmr_rerun_pass: got %b want 1", pass_s[U8]); end
        $display("test_reset_mid_run: rerun cycles=%0d pass=%b", cyc, pass_s[U8]);
    endtask

    task automatic test_start_while_busy();
        int cyc, en, w;
        bit pulsed;
        mode[U4] = 3;
        @(negedge clk) start_s[U4] = 1'b1;
        @(negedge clk) start_s[U4] = 1'b0;
        cyc = 0; en = 0; pulsed = 0;
        while (!done_s[U4] && cyc < 40) begin
            @(negedge clk);
            if (start_s[U4]) start_s[U4] = 1'b0;
            cyc++;
            if (test_en_s[U4]) en++;
            if (!pulsed && test_en_s[U4] && addr_s[U4] == 8'd2) begin start_s[U4] = 1'b1; pulsed = 1; end
        end
        n_cmp++; if (pulsed !== 1'b1) begin n_bad++; $display("FAIL swb_pulse: never reached addr 2"); end
        n_cmp++; if (cyc !== 6 || en !== 4) begin n_bad++; $display("FAIL swb_timing: cycles=%0d en=%0d, want 6 and 4", cyc, en); end
        n_cmp++; if (fail_s[U4] !== 9'd4 || ffv_s[U4] !== 1'b1 || ffa_s[U4] !== 8'd0) begin n_bad++; $display("FAIL swb_results: fail=%0d ffv=%b ffa=%0d, want 4 1 0", fail_s[U4], ffv_s[U4], ffa_s[U4]); end
        $display("test_start_while_busy: cycles=%0d fail=%0d", cyc, fail_s[U4]);
        mode[U4] = 0;
        @(negedge clk) start_s[U4] = 1'b1;
        @(negedge clk) start_s[U4] = 1'b0;
        n_cmp++; if (done_s[U4] !== 1'b0 || busy_s[U4] !== 1'b1 || pass_s[U4] !== 1'b0) begin n_bad++; $display("FAIL restart_seed: done=%b busy=%b pass=%b, want 0 1 0", done_s[U4], busy_s[U4], pass_s[U4]); end
        @(negedge clk);
        n_cmp++; if (fail_s[U4] !== 9'd0 || ffv_s[U4] !== 1'b0 || sig_s[U4] !== 16'h0000 || addr_s[U4] !== 8'd0) begin n_bad++; $display("FAIL restart_clear: fail=%0d ffv=%b sig=%h addr=%0d, want all 0", fail_s[U4], ffv_s[U4], sig_s[U4], addr_s[U4]); end
        w = 0;
        while (!done_s[U4] && w < 40) begin @(negedge clk); w++; end
        n_cmp++; if (done_s[U4] !== 1'b1 || pass_s[U4] !== 1'b1) begin n_bad++; $display("FAIL restart_pass: done=%b pass=%b, want 1 1", done_s[U4], pass_s[U4]); end
        $display("test_restart_from_done: pass=%b", pass_s[U4]);
    endtask

    task automatic test_full_length();
        int cyc, en;
        mode[U256] = 4;
        run(U256, cyc, en);
        n_cmp++; if (cyc !== 258 || en !== 256) begin n_bad++; $display("FAIL full_timing: cycles=%0d en=%0d, want 258 and 256", cyc, en); end
        n_cmp++; if (addr_s[U256] !== 8'd0) begin n_bad++; $display("FAIL full_addr_wrap: got %0d want 0", addr_s[U256]); end
        n_cmp++; if (fail_s[U256] !== 9'd0 || ffv_s[U256] !== 1'b0) begin n_bad++; $display("FAIL full_results: fail=%0d ffv=%b, want 0 0", fail_s[U256], ffv_s[U256]); end
        $display("test_full_length: cycles=%0d en=%0d addr=%0d fail=%0d", cyc, en, addr_s[U256], fail_s[U256]);
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_misr_shift();
        test_single_mismatch();
        test_reset_mid_run();
        test_start_while_busy();
        test_full_length();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
